bpu_update_queue: RTL and testbench

Scheduler for the branch target buffer's single write port. It collects resolved-taken branch updates from the two execute pipes (pipe0 older, pipe1 younger) into a small FIFO. Each pending update carries a delay-slot PC and a target, and updates that match a pending PC are merged in place. Entries drain one per cycle into the BTB under a valid/ready handshake, so two resolutions in the same cycle never collide on the BTB write.

---
 rtl/bpu_pkg.sv | 20 ++
 rtl/bpu_upq_match.sv | 35 +++
 rtl/bpu_update_queue.sv | 172 +++++++++++++++++
 tb/tb_bpu_update_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// bpu_pkg: constants and types shared across the branch prediction unit.
//   BPU_PC_W      - PC / target width used throughout the BPU
//   BPU_UPQ_DEPTH - default depth of the BTB update queue
//   upd_t         - one BTB update {pc, target}
//   bpu_ptr_w()   - pointer width for a power-of-two queue depth
package bpu_pkg;

   localparam int unsigned BPU_PC_W      = 32;
   localparam int unsigned BPU_UPQ_DEPTH = 4;

   typedef struct packed {
      logic [BPU_PC_W-1:0] pc;
      logic [BPU_PC_W-1:0] target;
   } upd_t;

   function automatic int unsigned bpu_ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/bpu_upq_match.sv
// bpu_upq_match: parallel compare of one incoming PC against every queue
// entry. Entries that are not valid, or that are being popped this cycle,
// never match. The result is one-hot (lowest index wins if several hit).
//   pc        in   incoming delay-slot PC
//   entry_pc  in   PC held in each queue slot
//   valid     in   slot currently holds a pending update
//   popping   in   slot is the head being written to the BTB this cycle
//   match     out  one-hot matching slot, zero when no match
module bpu_upq_match
   import bpu_pkg::*;
#(
   parameter int unsigned DEPTH = BPU_UPQ_DEPTH,
   parameter int unsigned PC_W  = BPU_PC_W
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [PC_W-1:0]  entry_pc [DEPTH],
   input  logic [DEPTH-1:0] valid,
   input  logic [DEPTH-1:0] popping,
   output logic [DEPTH-1:0] match
);

   logic [DEPTH-1:0] hit;

   always_comb begin
      hit = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         hit[i] = valid[i] & ~popping[i] & (entry_pc[i] == pc);
      end
   end

   // Isolate the lowest set bit so the result is one-hot even if the
   // invariant of unique pending PCs were ever broken.
   assign match = hit & (~hit + DEPTH'(1));

endmodule

// File: rtl/bpu_update_queue.sv
// bpu_update_queue: schedules resolved-taken branch updates from two execute
// pipes onto the BTB's single write port. Updates are held in a circular
// FIFO; an update whose PC is already pending (and not leaving this cycle)
// overwrites that entry's target instead of enqueuing.
//
// Ports
//   clk, resetn             clock, synchronous active-low reset
//   upd0_valid/pc/target    pipe0 update (older)
//   upd1_valid/pc/target    pipe1 update (younger)
//   upd_ready               queue has room for two updates this cycle
//   btb_wr_valid/pc/target  head entry presented to the BTB
//   btb_wr_ready            BTB accepts the head this cycle
//   stat_enq, stat_merge    saturating event counters (only with
//                           BPU_UPQ_STAT_EN defined)
//
// Build option: define BPU_UPQ_STAT_EN to add the statistics counters.
module bpu_update_queue
   import bpu_pkg::*;
#(
   parameter int unsigned DEPTH = BPU_UPQ_DEPTH,
   parameter int unsigned PC_W  = BPU_PC_W
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            upd0_valid,
   input  logic [PC_W-1:0] upd0_pc,
   input  logic [PC_W-1:0] upd0_target,
   input  logic            upd1_valid,
   input  logic [PC_W-1:0] upd1_pc,
   input  logic [PC_W-1:0] upd1_target,
   output logic            upd_ready,
   output logic            btb_wr_valid,
   output logic [PC_W-1:0] btb_wr_pc,
   output logic [PC_W-1:0] btb_wr_target,
`ifdef BPU_UPQ_STAT_EN
   output logic [15:0]     stat_enq,
   output logic [15:0]     stat_merge,
`endif
   input  logic            btb_wr_ready
);

   localparam int unsigned PTR_W = bpu_ptr_w(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PC_W-1:0]  ent_pc  [DEPTH];
   logic [PC_W-1:0]  ent_tgt [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic             accept;
   logic             pop;
   logic [DEPTH-1:0] valid_mask;
   logic [DEPTH-1:0] pop_mask;
   logic [DEPTH-1:0] m0;
   logic [DEPTH-1:0] m1;
   logic             v0, v1, same;
   logic             enq0, enq1, mrg0, mrg1;
   logic [PTR_W-1:0] slot0, slot1;
   logic [CNT_W-1:0] enq_cnt;
   logic [PTR_W-1:0] off;

   assign accept        = (count <= CNT_W'(DEPTH - 2));
   assign upd_ready     = accept;
   assign btb_wr_valid  = (count != '0);
   assign btb_wr_pc     = ent_pc[rd_ptr];
   assign btb_wr_target = ent_tgt[rd_ptr];
   assign pop           = btb_wr_valid & btb_wr_ready;

   // A slot is live when its distance from the head is below count.
   always_comb begin
      valid_mask = '0;
      pop_mask   = '0;
      off        = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off           = PTR_W'(i) - rd_ptr;
         valid_mask[i] = ({1'b0, off} < count);
         pop_mask[i]   = pop & (PTR_W'(i) == rd_ptr);
      end
   end

   bpu_upq_match #(
      .DEPTH (DEPTH),
      .PC_W  (PC_W)
   ) u_match0 (
      .pc       (upd0_pc),
      .entry_pc (ent_pc),
      .valid    (valid_mask),
      .popping  (pop_mask),
      .match    (m0)
   );

   bpu_upq_match #(
      .DEPTH (DEPTH),
      .PC_W  (PC_W)
   ) u_match1 (
      .pc       (upd1_pc),
      .entry_pc (ent_pc),
      .valid    (valid_mask),
      .popping  (pop_mask),
      .match    (m1)
   );

   // A same-PC pair is folded into upd1 alone: it carries the younger
   // target and either merges or enqueues exactly once.
   always_comb begin
      v0      = upd0_valid & accept;
      v1      = upd1_valid & accept;
      same    = v0 & v1 & (upd0_pc == upd1_pc);
      enq0    = v0 & ~same & ~(|m0);
      mrg0    = v0 & ~same &  (|m0);
      enq1    = v1 & ~(|m1);
      mrg1    = v1 &  (|m1);
      slot0   = wr_ptr;
      slot1   = wr_ptr + PTR_W'(enq0);
      enq_cnt = CNT_W'(enq0) + CNT_W'(enq1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_pc[i]  <= '0;
            ent_tgt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (enq0 && (slot0 == PTR_W'(i))) begin
               ent_pc[i]  <= upd0_pc;
               ent_tgt[i] <= upd0_target;
            end else if (mrg0 && m0[i]) begin
               ent_tgt[i] <= upd0_target;
            end
            if (enq1 && (slot1 == PTR_W'(i))) begin
               ent_pc[i]  <= upd1_pc;
               ent_tgt[i] <= upd1_target;
            end else if (mrg1 && m1[i]) begin
               ent_tgt[i] <= upd1_target;
            end
         end
         rd_ptr <= rd_ptr + PTR_W'(pop);
         wr_ptr <= wr_ptr + PTR_W'(enq_cnt);
         count  <= count + enq_cnt - CNT_W'(pop);
      end
   end

`ifdef BPU_UPQ_STAT_EN
   logic [1:0]  mrg_cnt;
   logic [16:0] enq_sum;
   logic [16:0] mrg_sum;

   // A same-PC pair is one merge event whatever happens to the result.
   always_comb begin
      mrg_cnt = same ? 2'd1 : (2'(mrg0) + 2'(mrg1));
      enq_sum = {1'b0, stat_enq}   + 17'(enq_cnt);
      mrg_sum = {1'b0, stat_merge} + 17'(mrg_cnt);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stat_enq   <= '0;
         stat_merge <= '0;
      end else begin
         stat_enq   <= enq_sum[16] ? '1 : enq_sum[15:0];
         stat_merge <= mrg_sum[16] ? '1 : mrg_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_bpu_update_queue.sv
// tb_bpu_update_queue: scoreboard bench for bpu_update_queue. The stimulus
// process drives each cycle and applies the update rules to a queue of
// pending {pc, target} records; a separate monitor compares the BTB write
// port against the queue head and retires records on each handshake.
module tb_bpu_update_queue;
   import bpu_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        upd0_valid, upd1_valid;
   logic [31:0] upd0_pc, upd0_target, upd1_pc, upd1_target;
   logic        upd_ready;
   logic        btb_wr_valid;
   logic [31:0] btb_wr_pc, btb_wr_target;
   logic        btb_wr_ready;
`ifdef BPU_UPQ_STAT_EN
   logic [15:0] stat_enq, stat_merge;
`endif

   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;
   upd_t mq[$];

   always #5 clk = ~clk;

   bpu_update_queue #(
      .DEPTH (DEPTH),
      .PC_W  (32)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .upd0_valid    (upd0_valid),
      .upd0_pc       (upd0_pc),
      .upd0_target   (upd0_target),
      .upd1_valid    (upd1_valid),
      .upd1_pc       (upd1_pc),
      .upd1_target   (upd1_target),
      .upd_ready     (upd_ready),
      .btb_wr_valid  (btb_wr_valid),
      .btb_wr_pc     (btb_wr_pc),
      .btb_wr_target (btb_wr_target),
`ifdef BPU_UPQ_STAT_EN
      .stat_enq      (stat_enq),
      .stat_merge    (stat_merge),
`endif
      .btb_wr_ready  (btb_wr_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rule: a pending record with the same PC takes the new
   // target; otherwise the update joins the tail.
   task automatic model_upd(input logic [31:0] pc, input logic [31:0] tgt);
      int idx = -1;
      for (int i = 0; i < mq.size(); i++)
         if (idx < 0 && mq[i].pc == pc) idx = i;
      if (idx >= 0) mq[idx].target = tgt;
      else begin
         upd_t u;
         u.pc = pc;
         u.target = tgt;
         mq.push_back(u);
      end
   endtask

   // One clock: drive at negedge, let the monitor retire the head just
   // before the edge, then apply the accepted updates after the edge.
   task automatic cyc(input bit rst, input bit v0, input logic [31:0] p0, input logic [31:0] t0,
                      input bit v1, input logic [31:0] p1, input logic [31:0] t1, input bit rdy);
      bit acc;
      @(negedge clk);
      resetn       = ~rst;
      upd0_valid   = v0;
      upd0_pc      = p0;
      upd0_target  = t0;
      upd1_valid   = v1;
      upd1_pc      = p1;
      upd1_target  = t1;
      btb_wr_ready = rdy;
      acc = (mq.size() <= DEPTH - 2);
      @(posedge clk);
      #1;
      if (rst) mq.delete();
      else if (acc) begin
         if (v0) model_upd(p0, t0);
         if (v1) model_upd(p1, t1);
      end
   endtask

   task automatic idle(input bit rdy);
      cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, rdy);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (mq.size() != 0 && n < budget) begin
         idle(1'b1);
         n++;
      end
      chk("drain_empty", 32'(mq.size()), 32'd0);
   endtask

   task automatic chk_reset_state();
      chk("rst_wr_valid", 32'(btb_wr_valid), 32'd0);
      chk("rst_wr_pc", btb_wr_pc, 32'd0);
      chk("rst_wr_target", btb_wr_target, 32'd0);
      chk("rst_upd_ready", 32'(upd_ready), 32'd1);
   endtask

   // Monitor: samples one time unit before each rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (mon_en) begin
            chk("wr_valid", 32'(btb_wr_valid), 32'(mq.size() != 0));
            chk("upd_ready", 32'(upd_ready), 32'(mq.size() <= DEPTH - 2));
            if (mq.size() != 0 && btb_wr_valid) begin
               chk("wr_pc", btb_wr_pc, mq[0].pc);
               chk("wr_target", btb_wr_target, mq[0].target);
               if (btb_wr_ready) void'(mq.pop_front());
            end
         end
      end
   end

   initial begin
      resetn = 1'b0;
      upd0_valid = 1'b0; upd0_pc = '0; upd0_target = '0;
      upd1_valid = 1'b0; upd1_pc = '0; upd1_target = '0;
      btb_wr_ready = 1'b0;

      cyc(1'b1, 0, '0, '0, 0, '0, '0, 1'b0);
      cyc(1'b1, 0, '0, '0, 0, '0, '0, 1'b0);
      chk_reset_state();
      mon_en = 1'b1;

      // Single update through an empty queue
      cyc(1'b0, 1, 32'h8000_0010, 32'h8000_0100, 0, '0, '0, 1'b1);
      idle(1'b1);
      idle(1'b1);
      drain(10);

      // Fill with distinct PCs while the BTB stalls, then release
      cyc(1'b0, 1, 32'h100, 32'hA0, 1, 32'h104, 32'hA1, 1'b0);
      cyc(1'b0, 1, 32'h108, 32'hA2, 1, 32'h10C, 32'hA3, 1'b0);
      cyc(1'b0, 1, 32'h110, 32'hA4, 1, 32'h114, 32'hA5, 1'b0);
      idle(1'b0);
      drain(10);

      // Merge into a non-head entry
      cyc(1'b0, 1, 32'h0800, 32'h900, 1, 32'h1000, 32'h2000, 1'b0);
      cyc(1'b0, 1, 32'h1000, 32'h3000, 0, '0, '0, 1'b0);
      drain(10);

      // Same-PC pair in one cycle
      cyc(1'b0, 1, 32'h40, 32'h50, 1, 32'h40, 32'h60, 1'b0);
      drain(10);

      // Update matching the head while it is popped
      cyc(1'b0, 1, 32'h40, 32'h50, 0, '0, '0, 1'b0);
      cyc(1'b0, 1, 32'h40, 32'h70, 0, '0, '0, 1'b1);
      drain(10);

      // Reset with three entries pending
      cyc(1'b0, 1, 32'h200, 32'h1, 1, 32'h204, 32'h2, 1'b0);
      cyc(1'b0, 1, 32'h208, 32'h3, 0, '0, '0, 1'b0);
      cyc(1'b1, 0, '0, '0, 0, '0, '0, 1'b1);
      chk_reset_state();
      for (int i = 0; i < 4; i++) idle(1'b1);

      // Random traffic over a small PC pool to provoke merges
      for (int i = 0; i < 1500; i++) begin
         cyc(1'b0,
             1'($urandom_range(0, 1)), 32'h300 + 4 * $urandom_range(0, 5), $urandom,
             1'($urandom_range(0, 1)), 32'h300 + 4 * $urandom_range(0, 5), $urandom,
             ($urandom_range(0, 9) < 6));
      end
      drain(50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
